imem_loader: RTL

Boot-time controller that streams a program image into the instruction memory over a byte-wide valid/ready channel, such as a UART receiver. It parses a length header, packs bytes little-endian into 32-bit words, drives the memory's synchronous write port, and verifies an XOR checksum. It holds the CPU core in reset until a load completes.

---
 rtl/riscv_boot_pkg.sv | 21 ++
 rtl/imem_word_packer.sv | 58 +++++
 rtl/imem_loader.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/riscv_boot_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package riscv_boot_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into words and keeps the running XOR checksum.
module imem_word_packer
    import riscv_boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic              last_byte_o,
    output logic              word_ready_o,
    output logic [WORD_W-1:0] word_o,
    output logic [BYTE_W-1:0] csum_o
);

    logic [BCNT_W-1:0] cnt_q,   cnt_d;
    logic [WORD_W-1:0] word_q,  word_d;
    logic [BYTE_W-1:0] csum_q,  csum_d;
    logic              ready_q, ready_d;

    // New bytes enter at the top so byte 0 ends up in the low lane after a full word.
    always_comb begin
        cnt_d   = cnt_q;
        word_d  = word_q;
        csum_d  = csum_q;
        ready_d = 1'b0;
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
            csum_d = '0;
        end else if (byte_en_i) begin
            cnt_d   = cnt_q + BCNT_W'(1);
            word_d  = {byte_i, word_q[WORD_W-1:BYTE_W]};
            csum_d  = csum_q ^ byte_i;
            ready_d = (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            ready_q <= ready_d;
        end
    end

    assign last_byte_o  = (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
    assign word_ready_o = ready_q;
    assign word_o       = word_q;
    assign csum_o       = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length header, streams packed words into instruction memory,
// verifies the XOR checksum and releases the core only after a good load.
module imem_loader
    import riscv_boot_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned AW        = $clog2(DEPTH),
    parameter bit          BOOT_HOLD = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_waddr_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic              cpu_hold_o,
    output logic [AW:0]       words_written_o
);

    loader_state_t     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [AW:0]       idx_q, idx_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic              rx_ready_q, rx_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_hold_q, cpu_hold_d;

    logic              accept_c;
    logic              clear_c;
    logic              byte_en_c;
    logic [LEN_W-1:0]  len_hdr_c;
    logic              last_byte;
    logic              word_ready;
    logic [BYTE_W-1:0] csum;

    imem_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_c),
        .byte_en_i    (byte_en_c),
        .byte_i       (rx_data_i),
        .last_byte_o  (last_byte),
        .word_ready_o (word_ready),
        .word_o       (mem_wdata_o),
        .csum_o       (csum)
    );

    // Next-state and registered-output decode; status outputs follow the state being entered.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        waddr_d   = waddr_q;
        clear_c   = 1'b0;
        byte_en_c = 1'b0;
        accept_c  = rx_valid_i && rx_ready_q;
        len_hdr_c = {rx_data_i, len_q[BYTE_W-1:0]};

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_d = ST_LEN_LO;
                    idx_d   = '0;
                    clear_c = 1'b1;
                end
            end
            ST_LEN_LO: begin
                if (accept_c) begin
                    len_d   = {{(LEN_W - BYTE_W){1'b0}}, rx_data_i};
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept_c) begin
                    len_d = len_hdr_c;
                    if ((len_hdr_c == '0) || (len_hdr_c > LEN_W'(DEPTH))) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept_c) begin
                    byte_en_c = 1'b1;
                    if (last_byte) begin
                        state_d = ST_WRITE;
                        waddr_d = idx_q[AW-1:0];
                    end
                end
            end
            ST_WRITE: begin
                idx_d = idx_q + (AW+1)'(1);
                if ((LEN_W'(idx_q) + LEN_W'(1)) == len_q) begin
                    state_d = ST_CSUM;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (accept_c) begin
                    state_d = (rx_data_i == csum) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rx_ready_d = (state_d inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM});
        busy_d     = (state_d inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_CSUM});
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERROR);
        cpu_hold_d = cpu_hold_q;
        if (state_d == ST_DONE) begin
            cpu_hold_d = 1'b0;
        end else if (state_d != ST_IDLE) begin
            cpu_hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            waddr_q    <= '0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= BOOT_HOLD;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            waddr_q    <= waddr_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    assign rx_ready_o      = rx_ready_q;
    assign mem_we_o        = word_ready;
    assign mem_waddr_o     = waddr_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign cpu_hold_o      = cpu_hold_q;
    assign words_written_o = idx_q;

endmodule
